// File: rtl/e_tile_target_dispatcher.sv
// e_tile_target_dispatcher
// Buffers fired ALU results in a small FIFO. For each result it issues the
// valid targets in order (target 0, then target 1). Each target goes out on
// either the operand-network sender or the register-bank W-queue write port,
// using a req/ack handshake on that port.
//
// Ports
//   clk, rst            clock (rising edge) and asynchronous active-high reset
//   flush               synchronous abandon: empties the FIFO and returns to IDLE
//   in_valid/in_ready   fired-result handshake; in_ready comes from the
//                       registered count
//   in_data, in_tgt_*   result data and per-target valid / wq / instr / slot
//   net_*               network sender handshake and payload
//   wq_*                W-queue handshake and payload
//   occupancy, busy     FIFO entry count; FSM active or FIFO non-empty
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transfer; inspects the head entry whenever the FIFO is non-empty
// SEND0 | presenting target 0 of the head entry, waiting for its ack
// SEND1 | presenting target 1 of the head entry, waiting for its ack
module e_tile_target_dispatcher #(
    parameter int          DEPTH  = 4,
    parameter int          DATA_W = 32,
    parameter logic [7:0]  SRC_ID = 8'd0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [1:0]                 in_tgt_valid,
    input  logic [1:0]                 in_tgt_wq,
    input  logic [1:0][6:0]            in_tgt_instr,
    input  logic [1:0][1:0]            in_tgt_slot,
    output logic                       net_req,
    input  logic                       net_ack,
    output logic [DATA_W-1:0]          net_data,
    output logic [7:0]                 net_src,
    output logic [6:0]                 net_dest_instr,
    output logic [1:0]                 net_dest_slot,
    output logic                       wq_req,
    input  logic                       wq_ack,
    output logic [6:0]                 wq_reg_id,
    output logic [4:0]                 wq_queue_id,
    output logic [DATA_W-1:0]          wq_data,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, SEND0, SEND1} state_t;

    state_t          state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic [DATA_W-1:0] mem_data  [DEPTH];
    logic [1:0]        mem_tv    [DEPTH];
    logic [1:0]        mem_wq    [DEPTH];
    logic [1:0][6:0]   mem_instr [DEPTH];
    logic [1:0][1:0]   mem_slot  [DEPTH];

    logic [DATA_W-1:0] head_data;
    logic [1:0]        head_tv;
    logic [1:0]        head_wq;
    logic [1:0][6:0]   head_instr;
    logic [1:0][1:0]   head_slot;

    logic       push;
    logic       pop;
    logic       sel;
    logic       active;
    logic       xfer_done;
    logic [6:0] act_instr;
    logic [1:0] act_slot;

    assign head_data  = mem_data[rd_ptr];
    assign head_tv    = mem_tv[rd_ptr];
    assign head_wq    = mem_wq[rd_ptr];
    assign head_instr = mem_instr[rd_ptr];
    assign head_slot  = mem_slot[rd_ptr];

    assign in_ready  = (count < CW'(DEPTH));
    assign push      = in_valid && in_ready;
    assign occupancy = count;
    assign busy      = (state != IDLE) || (count != '0);

    // The active target is target 1 only in SEND1. Requests are decoded from
    // the head entry, so they stay stable for as long as the head is held.
    assign sel       = (state == SEND1);
    assign active    = (state != IDLE);
    assign act_instr = head_instr[sel];
    assign act_slot  = head_slot[sel];
    assign net_req   = active && !head_wq[sel];
    assign wq_req    = active &&  head_wq[sel];
    assign xfer_done = (net_req && net_ack) || (wq_req && wq_ack);

    assign net_data       = net_req ? head_data : '0;
    assign net_src        = net_req ? SRC_ID    : '0;
    assign net_dest_instr = net_req ? act_instr : '0;
    assign net_dest_slot  = net_req ? act_slot  : '0;
    assign wq_data        = wq_req  ? head_data : '0;
    assign wq_reg_id      = wq_req  ? act_instr : '0;
    assign wq_queue_id    = wq_req  ? act_instr[4:0] : '0;

    // The head entry is popped when its last valid target has completed.
    // An entry with no valid targets is popped straight from IDLE.
    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:    pop = (count != '0) && (head_tv == 2'b00);
            SEND0:   pop = xfer_done && !head_tv[1];
            SEND1:   pop = xfer_done;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        if (head_tv[0])      state <= SEND0;
                        else if (head_tv[1]) state <= SEND1;
                    end
                end
                SEND0: begin
                    if (xfer_done) state <= head_tv[1] ? SEND1 : IDLE;
                end
                SEND1: begin
                    if (xfer_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_data[wr_ptr]  <= in_data;
            mem_tv[wr_ptr]    <= in_tgt_valid;
            mem_wq[wr_ptr]    <= in_tgt_wq;
            mem_instr[wr_ptr] <= in_tgt_instr;
            mem_slot[wr_ptr]  <= in_tgt_slot;
        end
    end

endmodule

// File: tb/tb_e_tile_target_dispatcher.sv
module tb_e_tile_target_dispatcher;

    localparam int         DEPTH  = 4;
    localparam int         DATA_W = 32;
    localparam logic [7:0] SRC    = 8'h5A;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_tgt_valid;
    logic [1:0]        in_tgt_wq;
    logic [1:0][6:0]   in_tgt_instr;
    logic [1:0][1:0]   in_tgt_slot;
    logic              net_req;
    logic              net_ack;
    logic [DATA_W-1:0] net_data;
    logic [7:0]        net_src;
    logic [6:0]        net_dest_instr;
    logic [1:0]        net_dest_slot;
    logic              wq_req;
    logic              wq_ack;
    logic [6:0]        wq_reg_id;
    logic [4:0]        wq_queue_id;
    logic [DATA_W-1:0] wq_data;
    logic [2:0]        occupancy;
    logic              busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    e_tile_target_dispatcher #(.DEPTH(DEPTH), .DATA_W(DATA_W), .SRC_ID(SRC)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_tgt_valid(in_tgt_valid), .in_tgt_wq(in_tgt_wq),
        .in_tgt_instr(in_tgt_instr), .in_tgt_slot(in_tgt_slot),
        .net_req(net_req), .net_ack(net_ack), .net_data(net_data),
        .net_src(net_src), .net_dest_instr(net_dest_instr),
        .net_dest_slot(net_dest_slot),
        .wq_req(wq_req), .wq_ack(wq_ack), .wq_reg_id(wq_reg_id),
        .wq_queue_id(wq_queue_id), .wq_data(wq_data),
        .occupancy(occupancy), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_entry(input logic [31:0] d, input logic [1:0] tv, input logic [1:0] wq,
                             input logic [6:0] i0, input logic [1:0] s0,
                             input logic [6:0] i1, input logic [1:0] s1);
        in_data         = d;
        in_tgt_valid    = tv;
        in_tgt_wq       = wq;
        in_tgt_instr[0] = i0;
        in_tgt_slot[0]  = s0;
        in_tgt_instr[1] = i1;
        in_tgt_slot[1]  = s1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_net_req"}, 64'(net_req), 64'd0);
        chk({tag, "_wq_req"}, 64'(wq_req), 64'd0);
        chk({tag, "_net_data"}, 64'(net_data), 64'd0);
        chk({tag, "_net_src"}, 64'(net_src), 64'd0);
        chk({tag, "_net_instr"}, 64'(net_dest_instr), 64'd0);
        chk({tag, "_wq_reg"}, 64'(wq_reg_id), 64'd0);
        chk({tag, "_wq_data"}, 64'(wq_data), 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; net_ack = 1'b0; wq_ack = 1'b0;
        set_entry(32'h0, 2'b00, 2'b00, 7'd0, 2'd0, 7'd0, 2'd0);
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk_idle_outputs("rst");
        tick(); tick();
        rst = 1'b0;
        tick();

        // two network targets, ack tied high
        net_ack = 1'b1;
        set_entry(32'hDEADBEEF, 2'b11, 2'b00, 7'd5, 2'd1, 7'd9, 2'd2);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t2_occ1", 64'(occupancy), 64'd1);
        chk("t2_noreq_yet", 64'(net_req), 64'd0);
        tick();
        chk("t2_req0", 64'(net_req), 64'd1);
        chk("t2_instr0", 64'(net_dest_instr), 64'd5);
        chk("t2_slot0", 64'(net_dest_slot), 64'd1);
        chk("t2_data0", 64'(net_data), 64'hDEADBEEF);
        chk("t2_src0", 64'(net_src), 64'(SRC));
        chk("t2_wq0", 64'(wq_req), 64'd0);
        tick();
        chk("t2_req1", 64'(net_req), 64'd1);
        chk("t2_instr1", 64'(net_dest_instr), 64'd9);
        chk("t2_slot1", 64'(net_dest_slot), 64'd2);
        chk("t2_data1", 64'(net_data), 64'hDEADBEEF);
        tick();
        chk("t2_occ_end", 64'(occupancy), 64'd0);
        chk("t2_busy_end", 64'(busy), 64'd0);
        chk_idle_outputs("t2_end");

        // mixed targets, stalled W-queue ack
        set_entry(32'h12345678, 2'b11, 2'b10, 7'd3, 2'd0, 7'h23, 2'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t3_net_req", 64'(net_req), 64'd1);
        chk("t3_net_instr", 64'(net_dest_instr), 64'd3);
        chk("t3_no_wq", 64'(wq_req), 64'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t3_wq_hold", 64'(wq_req), 64'd1);
            chk("t3_no_overlap", 64'(net_req), 64'd0);
            chk("t3_qid", 64'(wq_queue_id), 64'h03);
            chk("t3_reg", 64'(wq_reg_id), 64'h23);
            chk("t3_data", 64'(wq_data), 64'h12345678);
            tick();
        end
        wq_ack = 1'b1;
        chk("t3_wq_6th", 64'(wq_req), 64'd1);
        tick();
        wq_ack = 1'b0;
        chk("t3_wq_done", 64'(wq_req), 64'd0);
        chk("t3_occ", 64'(occupancy), 64'd0);

        // entry with no targets
        set_entry(32'hCAFE0000, 2'b00, 2'b00, 7'd1, 2'd0, 7'd2, 2'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t5_occ1", 64'(occupancy), 64'd1);
        chk("t5_busy1", 64'(busy), 64'd1);
        chk("t5_nreq", 64'(net_req), 64'd0);
        chk("t5_wreq", 64'(wq_req), 64'd0);
        tick();
        chk("t5_occ0", 64'(occupancy), 64'd0);
        chk("t5_busy0", 64'(busy), 64'd0);
        chk_idle_outputs("t5");

        // fill the FIFO with net_ack low, then drain
        net_ack = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_entry(32'hA0 + 32'(k), 2'b01, 2'b00, 7'(k + 1), 2'd0, 7'd0, 2'd0);
            tick();
        end
        chk("t4_full_ready", 64'(in_ready), 64'd0);
        chk("t4_full_occ", 64'(occupancy), 64'd4);
        set_entry(32'hFF, 2'b01, 2'b00, 7'd5, 2'd0, 7'd0, 2'd0);
        tick();
        in_valid = 1'b0;
        chk("t4_5th_occ", 64'(occupancy), 64'd4);
        chk("t4_5th_ready", 64'(in_ready), 64'd0);
        net_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t4_drain_req", 64'(net_req), 64'd1);
            chk("t4_drain_instr", 64'(net_dest_instr), 64'(k + 1));
            chk("t4_drain_data", 64'(net_data), 64'(32'hA0 + 32'(k)));
            tick();
            chk("t4_bubble", 64'(net_req), 64'd0);
            chk("t4_occ", 64'(occupancy), 64'(3 - k));
            chk("t4_ready", 64'(in_ready), 64'd1);
            tick();
        end
        chk("t4_empty_busy", 64'(busy), 64'd0);

        // flush mid-transfer with ack high and a same-cycle push
        set_entry(32'h55, 2'b11, 2'b00, 7'd7, 2'd0, 7'd8, 2'd1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t6_req_before", 64'(net_req), 64'd1);
        flush = 1'b1;
        set_entry(32'h66, 2'b01, 2'b00, 7'h11, 2'd0, 7'd0, 2'd0);
        in_valid = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t6_occ", 64'(occupancy), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk_idle_outputs("t6");
        tick();
        chk("t6_never_sent", 64'(net_req), 64'd0);
        chk("t6_occ_later", 64'(occupancy), 64'd0);

        // asynchronous reset mid-SEND0
        net_ack = 1'b0;
        set_entry(32'h77, 2'b01, 2'b00, 7'd6, 2'd1, 7'd0, 2'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t1_req_before", 64'(net_req), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("t1_occ", 64'(occupancy), 64'd0);
        chk("t1_ready", 64'(in_ready), 64'd1);
        chk("t1_busy", 64'(busy), 64'd0);
        chk_idle_outputs("t1");
        tick();
        rst = 1'b0;
        tick();
        chk("t1_after_occ", 64'(occupancy), 64'd0);
        chk("t1_after_req", 64'(net_req), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
